// File: rtl/ftdi_fifo_if_pkg.sv
// Shared types and timing defaults for the FT232H 245-FIFO bridge.
package ftdi_pkg;

    localparam int CNT_W = 4;

    localparam int RD_PULSE_DEF = 4;
    localparam int WR_PULSE_DEF = 4;
    localparam int SETUP_DEF    = 1;
    localparam int RECOVER_DEF  = 3;
    localparam int TURN_DEF     = 2;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_RD_STROBE  = 3'd1;
    localparam logic [2:0] S_RD_RECOVER = 3'd2;
    localparam logic [2:0] S_TURN_OUT   = 3'd3;
    localparam logic [2:0] S_WR_SETUP   = 3'd4;
    localparam logic [2:0] S_WR_STROBE  = 3'd5;
    localparam logic [2:0] S_WR_RECOVER = 3'd6;
    localparam logic [2:0] S_TURN_IN    = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE       = S_IDLE,
        ST_RD_STROBE  = S_RD_STROBE,
        ST_RD_RECOVER = S_RD_RECOVER,
        ST_TURN_OUT   = S_TURN_OUT,
        ST_WR_SETUP   = S_WR_SETUP,
        ST_WR_STROBE  = S_WR_STROBE,
        ST_WR_RECOVER = S_WR_RECOVER,
        ST_TURN_IN    = S_TURN_IN
    } ftdi_state_t;

endpackage

// File: rtl/ftdi_fifo_if_if.sv
// Internal byte streams between the FTDI bridge (slave) and the LaserDrop core (master).
interface ftdi_stream_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (input rx_data, rx_valid, tx_ready, output rx_ready, tx_data, tx_valid);
    modport slave  (output rx_data, rx_valid, tx_ready, input rx_ready, tx_data, tx_valid);
endinterface

// File: rtl/ftdi_fifo_if_sync2.sv
// Two-flop synchroniser for an active-low asynchronous flag; resets to inactive (1).
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_r;
    logic sync_r;

    // Metastability chain.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/ftdi_fifo_if.sv
// FT232H 245-FIFO pin bridge to one-entry rx/tx byte streams.
// Every FTDI pin output is registered from the next FSM state.
module ftdi_fifo_if
    import ftdi_pkg::*;
#(
    parameter int RD_PULSE_CYCLES = RD_PULSE_DEF,
    parameter int WR_PULSE_CYCLES = WR_PULSE_DEF,
    parameter int SETUP_CYCLES    = SETUP_DEF,
    parameter int RECOVER_CYCLES  = RECOVER_DEF,
    parameter int TURN_CYCLES     = TURN_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         rxf_n,
    input  logic         txe_n,
    input  logic [7:0]   adbus_in,
    output logic [7:0]   adbus_out,
    output logic         adbus_tri,
    output logic         ftdi_rd_n,
    output logic         ftdi_wr_n,
    ftdi_stream_if.slave strm,
    output logic         busy
);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    ftdi_state_t      state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             cnt_done_s;
    logic             rxf_s, txe_s;
    logic             rd_elig_s, wr_elig_s;
    logic             last_rd_r;
    logic [7:0]       rx_data_r, tx_buf_r, adbus_out_r;
    logic             rx_valid_r, tx_ready_r;
    logic             rd_n_r, wr_n_r, tri_r, busy_r;

    // RD_RECOVER is one short: the following IDLE cycle completes the strobe-high gap.
    function automatic logic [CNT_W-1:0] entry_count(input ftdi_state_t st);
        case (st)
            ST_RD_STROBE:  entry_count = CNT_W'(RD_PULSE_CYCLES - 1);
            ST_RD_RECOVER: entry_count = CNT_W'(RECOVER_CYCLES - 2);
            ST_TURN_OUT:   entry_count = CNT_W'(TURN_CYCLES - 1);
            ST_WR_SETUP:   entry_count = CNT_W'(SETUP_CYCLES - 1);
            ST_WR_STROBE:  entry_count = CNT_W'(WR_PULSE_CYCLES - 1);
            ST_TURN_IN:    entry_count = CNT_W'(RECOVER_CYCLES - 1);
            default:       entry_count = CNT_ZERO;
        endcase
    endfunction

    sync2 u_sync_rxf (.clock(clock), .reset(reset), .d(rxf_n), .q(rxf_s));
    sync2 u_sync_txe (.clock(clock), .reset(reset), .d(txe_n), .q(txe_s));

    assign cnt_done_s = (cnt_r == CNT_ZERO);
    assign rd_elig_s  = !rxf_s && (!rx_valid_r || strm.rx_ready);
    assign wr_elig_s  = !txe_s && !tx_ready_r;

    // Next-state decode; flags are only looked at in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rd_elig_s && wr_elig_s) begin
                    state_nxt_s = last_rd_r ? ST_TURN_OUT : ST_RD_STROBE;
                end else if (rd_elig_s) begin
                    state_nxt_s = ST_RD_STROBE;
                end else if (wr_elig_s) begin
                    state_nxt_s = ST_TURN_OUT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_STROBE:  state_nxt_s = cnt_done_s ? ST_RD_RECOVER : ST_RD_STROBE;
            ST_RD_RECOVER: state_nxt_s = cnt_done_s ? ST_IDLE       : ST_RD_RECOVER;
            ST_TURN_OUT:   state_nxt_s = cnt_done_s ? ST_WR_SETUP   : ST_TURN_OUT;
            ST_WR_SETUP:   state_nxt_s = cnt_done_s ? ST_WR_STROBE  : ST_WR_SETUP;
            ST_WR_STROBE:  state_nxt_s = cnt_done_s ? ST_WR_RECOVER : ST_WR_STROBE;
            ST_WR_RECOVER: state_nxt_s = ST_TURN_IN;
            ST_TURN_IN:    state_nxt_s = cnt_done_s ? ST_IDLE       : ST_TURN_IN;
            default:       state_nxt_s = ST_IDLE;
        endcase
    end

    // State, shared timing counter and round-robin bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            last_rd_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s != state_r) begin
                cnt_r <= entry_count(state_nxt_s);
            end else if (!cnt_done_s) begin
                cnt_r <= cnt_r - CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
            if (state_r == ST_RD_STROBE && cnt_done_s) begin
                last_rd_r <= 1'b1;
            end else if (state_r == ST_WR_RECOVER) begin
                last_rd_r <= 1'b0;
            end else begin
                last_rd_r <= last_rd_r;
            end
        end
    end

    // Pin outputs decoded from the next state so they change with the state itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_n_r      <= 1'b1;
            wr_n_r      <= 1'b1;
            tri_r       <= 1'b0;
            busy_r      <= 1'b0;
            adbus_out_r <= 8'h00;
        end else begin
            rd_n_r <= (state_nxt_s != ST_RD_STROBE);
            wr_n_r <= (state_nxt_s != ST_WR_STROBE);
            tri_r  <= (state_nxt_s == ST_WR_SETUP) || (state_nxt_s == ST_WR_STROBE) ||
                      (state_nxt_s == ST_WR_RECOVER);
            busy_r <= (state_nxt_s != ST_IDLE);
            if (state_r == ST_TURN_OUT) begin
                adbus_out_r <= tx_buf_r;
            end else begin
                adbus_out_r <= adbus_out_r;
            end
        end
    end

    // One-entry RX and TX holding registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            tx_buf_r   <= 8'h00;
            tx_ready_r <= 1'b1;
        end else begin
            if (state_r == ST_RD_STROBE && cnt_done_s) begin
                rx_data_r  <= adbus_in;
                rx_valid_r <= 1'b1;
            end else if (strm.rx_ready) begin
                rx_data_r  <= rx_data_r;
                rx_valid_r <= 1'b0;
            end else begin
                rx_data_r  <= rx_data_r;
                rx_valid_r <= rx_valid_r;
            end
            if (state_r == ST_WR_RECOVER) begin
                tx_buf_r   <= tx_buf_r;
                tx_ready_r <= 1'b1;
            end else if (strm.tx_valid && tx_ready_r) begin
                tx_buf_r   <= strm.tx_data;
                tx_ready_r <= 1'b0;
            end else begin
                tx_buf_r   <= tx_buf_r;
                tx_ready_r <= tx_ready_r;
            end
        end
    end

    assign ftdi_rd_n     = rd_n_r;
    assign ftdi_wr_n     = wr_n_r;
    assign adbus_tri     = tri_r;
    assign adbus_out     = adbus_out_r;
    assign busy          = busy_r;
    assign strm.rx_data  = rx_data_r;
    assign strm.rx_valid = rx_valid_r;
    assign strm.tx_ready = tx_ready_r;
endmodule

// File: tb/tb_ftdi_fifo_if.sv
// Directed bench for ftdi_fifo_if with a small FT232H FIFO model on the pin side.
`timescale 1ns/1ps
module tb_ftdi_fifo_if;
    import ftdi_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       txe_n;
    logic       glitch_n;
    logic       rxf_n;
    logic [7:0] adbus_in;
    logic [7:0] adbus_out;
    logic       adbus_tri, ftdi_rd_n, ftdi_wr_n, busy;

    ftdi_stream_if strm ();

    logic [7:0] host_mem [0:31];
    int         host_wr;
    int         host_rd = 0;
    logic [7:0] rx_log [$];
    logic [7:0] wr_log [$];
    logic [7:0] op_log [$];
    int         rd_cnt = 0, rd_len = 0, rd_bad = 0, overlap = 0;
    int         n_checks = 0, n_fail = 0;

    ftdi_fifo_if dut (
        .clock(clock), .reset(reset), .rxf_n(rxf_n), .txe_n(txe_n),
        .adbus_in(adbus_in), .adbus_out(adbus_out), .adbus_tri(adbus_tri),
        .ftdi_rd_n(ftdi_rd_n), .ftdi_wr_n(ftdi_wr_n), .strm(strm), .busy(busy)
    );

    always #10 clock = ~clock;

    // FTDI model: RXF# low while host bytes remain; a byte is consumed when RD# rises.
    assign rxf_n    = glitch_n & (host_rd == host_wr);
    assign adbus_in = host_mem[host_rd[4:0]];

    always @(posedge ftdi_rd_n) begin
        if (host_rd < host_wr) host_rd = host_rd + 1;
    end

    always @(posedge ftdi_wr_n) begin
        if (reset === 1'b0) wr_log.push_back(adbus_out);
    end

    always @(negedge ftdi_rd_n or negedge ftdi_wr_n) begin
        if (ftdi_rd_n === 1'b0) begin
            op_log.push_back(8'h52);
            rd_cnt = rd_cnt + 1;
        end
        if (ftdi_wr_n === 1'b0) op_log.push_back(8'h57);
    end

    always @(posedge clock) begin
        if (strm.rx_valid === 1'b1 && strm.rx_ready === 1'b1) rx_log.push_back(strm.rx_data);
    end

    // RD# pulse width and bus-direction overlap, sampled mid-cycle.
    always @(negedge clock) begin
        if (ftdi_rd_n === 1'b0 && adbus_tri === 1'b1) overlap = overlap + 1;
        if (ftdi_rd_n === 1'b0) begin
            rd_len = rd_len + 1;
        end else if (rd_len != 0) begin
            if (rd_len != RD_PULSE_DEF) rd_bad = rd_bad + 1;
            rd_len = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic hs;
    int   sent, rd0, rx0, wr0, op0;
    bit   found;

    initial begin
        reset = 1'b1; txe_n = 1'b1; glitch_n = 1'b1; host_wr = 0;
        strm.rx_ready = 1'b0; strm.tx_valid = 1'b0; strm.tx_data = 8'h00;
        for (int i = 0; i < 32; i++) host_mem[i] = 8'h00;
        repeat (3) tick();

        check_eq("rst_rd_n",     32'(ftdi_rd_n),     32'h1);
        check_eq("rst_wr_n",     32'(ftdi_wr_n),     32'h1);
        check_eq("rst_tri",      32'(adbus_tri),     32'h0);
        check_eq("rst_adbus",    32'(adbus_out),     32'h0);
        check_eq("rst_rx_valid", 32'(strm.rx_valid), 32'h0);
        check_eq("rst_rx_data",  32'(strm.rx_data),  32'h0);
        check_eq("rst_tx_ready", 32'(strm.tx_ready), 32'h1);
        check_eq("rst_busy",     32'(busy),          32'h0);
        reset = 1'b0;
        repeat (3) tick();

        // 1: single read, then a second queued byte held off by rx_ready=0
        host_mem[0] = 8'hA5; host_mem[1] = 8'hB6; host_wr = 2; rd0 = rd_cnt;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_eq("t1_rd_n",     32'(ftdi_rd_n),     32'(!(k >= 3 && k <= 6)));
            check_eq("t1_rx_valid", 32'(strm.rx_valid), 32'(k >= 7));
            if (k == 7) check_eq("t1_rx_data", 32'(strm.rx_data), 32'hA5);
        end
        repeat (15) tick();
        check_eq("t1_no_second_rd", 32'(rd_cnt - rd0), 32'd1);
        strm.rx_ready = 1'b1; tick(); strm.rx_ready = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (strm.rx_valid === 1'b1) found = 1'b1;
        end
        check_eq("t1_second_valid", 32'(found),        32'h1);
        check_eq("t1_second_data",  32'(strm.rx_data), 32'hB6);
        check_eq("t1_first_taken",  32'(rx_log.size() > 0 ? rx_log[0] : 8'hFF), 32'hA5);
        strm.rx_ready = 1'b1; tick(); strm.rx_ready = 1'b0;
        repeat (5) tick();

        // 2: single write of 3C
        txe_n = 1'b0; repeat (4) tick();
        wr0 = wr_log.size();
        strm.tx_data = 8'h3C; strm.tx_valid = 1'b1;
        tick();
        check_eq("t2_tx_ready_drop", 32'(strm.tx_ready), 32'h0);
        strm.tx_valid = 1'b0;
        for (int k = 2; k <= 13; k++) begin
            tick();
            check_eq("t2_tri",  32'(adbus_tri), 32'(k >= 4 && k <= 9));
            check_eq("t2_wr_n", 32'(ftdi_wr_n), 32'(!(k >= 5 && k <= 8)));
            if (k >= 4 && k <= 9) check_eq("t2_adbus_out", 32'(adbus_out), 32'h3C);
            check_eq("t2_tx_ready", 32'(strm.tx_ready), 32'(k >= 10));
            check_eq("t2_busy",     32'(busy),          32'(k <= 12));
        end
        check_eq("t2_host_got", 32'(wr_log.size() > wr0 ? wr_log[wr0] : 8'hFF), 32'h3C);

        // 3: contention with both flags held
        reset = 1'b1;
        host_mem[2] = 8'hC1; host_mem[3] = 8'hC2; host_wr = 4;
        txe_n = 1'b0; strm.rx_ready = 1'b1; strm.tx_data = 8'h01; strm.tx_valid = 1'b1;
        repeat (3) tick();
        op0 = op_log.size(); wr0 = wr_log.size(); rx0 = rx_log.size(); sent = 0;
        reset = 1'b0;
        for (int c = 0; c < 150 && (wr_log.size() - wr0) < 2; c++) begin
            hs = strm.tx_valid && strm.tx_ready;
            tick();
            if (hs) begin
                sent++;
                if (sent == 1) strm.tx_data = 8'h02;
                else strm.tx_valid = 1'b0;
            end
        end
        repeat (10) tick();
        for (int i = 0; i < 4; i++)
            check_eq("t3_op_order", 32'((op0 + i) < op_log.size() ? op_log[op0 + i] : 8'hFF),
                     32'((i % 2 == 0) ? 8'h52 : 8'h57));
        check_eq("t3_wr0", 32'((wr0 + 0) < wr_log.size() ? wr_log[wr0 + 0] : 8'hFF), 32'h01);
        check_eq("t3_wr1", 32'((wr0 + 1) < wr_log.size() ? wr_log[wr0 + 1] : 8'hFF), 32'h02);
        check_eq("t3_rx0", 32'((rx0 + 0) < rx_log.size() ? rx_log[rx0 + 0] : 8'hFF), 32'hC1);
        check_eq("t3_rx1", 32'((rx0 + 1) < rx_log.size() ? rx_log[rx0 + 1] : 8'hFF), 32'hC2);
        check_eq("t3_overlap", 32'(overlap), 32'd0);

        // 4: backpressure on three host bytes
        reset = 1'b1; txe_n = 1'b1; strm.rx_ready = 1'b0; strm.tx_valid = 1'b0;
        host_mem[4] = 8'h11; host_mem[5] = 8'h22; host_mem[6] = 8'h33; host_wr = 7;
        repeat (3) tick();
        rd0 = rd_cnt; rx0 = rx_log.size();
        reset = 1'b0;
        repeat (20) tick();
        check_eq("t4_stall_reads", 32'(rd_cnt - rd0),   32'd1);
        check_eq("t4_stall_valid", 32'(strm.rx_valid),  32'h1);
        check_eq("t4_stall_data",  32'(strm.rx_data),   32'h11);
        strm.rx_ready = 1'b1;
        for (int c = 0; c < 60 && (rx_log.size() - rx0) < 3; c++) tick();
        repeat (10) tick();
        check_eq("t4_count", 32'(rx_log.size() - rx0), 32'd3);
        check_eq("t4_b0", 32'((rx0 + 0) < rx_log.size() ? rx_log[rx0 + 0] : 8'hFF), 32'h11);
        check_eq("t4_b1", 32'((rx0 + 1) < rx_log.size() ? rx_log[rx0 + 1] : 8'hFF), 32'h22);
        check_eq("t4_b2", 32'((rx0 + 2) < rx_log.size() ? rx_log[rx0 + 2] : 8'hFF), 32'h33);
        check_eq("t4_reads", 32'(rd_cnt - rd0), 32'd3);

        // 5: reset in the second WR_STROBE cycle, then a clean write of 77
        txe_n = 1'b0; repeat (4) tick();
        strm.tx_data = 8'h55; strm.tx_valid = 1'b1;
        tick();
        strm.tx_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            tick();
            if (ftdi_wr_n === 1'b0) found = 1'b1;
        end
        check_eq("t5_strobe_seen", 32'(found), 32'h1);
        tick();
        reset = 1'b1;
        tick();
        check_eq("t5_wr_n",    32'(ftdi_wr_n),     32'h1);
        check_eq("t5_tri",     32'(adbus_tri),     32'h0);
        check_eq("t5_tx_ready",32'(strm.tx_ready), 32'h1);
        check_eq("t5_busy",    32'(busy),          32'h0);
        reset = 1'b0;
        wr0 = wr_log.size();
        strm.tx_data = 8'h77; strm.tx_valid = 1'b1;
        tick();
        strm.tx_valid = 1'b0;
        for (int c = 0; c < 40 && wr_log.size() == wr0; c++) tick();
        repeat (6) tick();
        check_eq("t5_post_count", 32'(wr_log.size() - wr0), 32'd1);
        check_eq("t5_post_byte",  32'(wr_log.size() > wr0 ? wr_log[wr0] : 8'hFF), 32'h77);
        check_eq("t5_post_idle",  32'(busy), 32'h0);

        // 6: one-cycle RXF# glitch while idle
        txe_n = 1'b1; strm.rx_ready = 1'b1;
        repeat (5) tick();
        rd0 = rd_cnt;
        glitch_n = 1'b0; tick(); glitch_n = 1'b1;
        repeat (25) tick();
        check_eq("t6_reads_le1", 32'((rd_cnt - rd0) <= 1), 32'h1);
        check_eq("t6_idle",      32'(busy),    32'h0);
        check_eq("t6_rd_width",  32'(rd_bad),  32'd0);
        check_eq("t6_overlap",   32'(overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ftdi_fifo_if.md
Name: ftdi_fifo_if

Overview:
Bridges the FT232H asynchronous 245-FIFO pins (RXF#, TXE#, RD#, WR#, ADBUS[7:0]) to internal valid/ready byte streams for the LaserDrop datapath. Host-to-laser bytes are read from the FTDI and presented on rx_*. Laser-to-host bytes are accepted on tx_* and written to the FTDI. The block sits between the GPIO_0 pin mapping and the LaserDrop core. It owns the adbus_tri direction control and all strobe timing at the 50 MHz clock.

Parameters:
RD_PULSE_CYCLES, 4, cycles RD# is held low; adbus_in is sampled on the last of these cycles (minimum 2).
WR_PULSE_CYCLES, 4, cycles WR# is held low with data stable (minimum 2).
SETUP_CYCLES, 1, cycles data is driven before WR# falls.
RECOVER_CYCLES, 3, cycles strobes stay high between operations (minimum 3, so that the synchroniser flushes stale flags).
TURN_CYCLES, 2, bus-idle cycles when changing adbus direction.

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
rxf_n  in  1  FTDI RXF#; low means a byte is available (asynchronous)
txe_n  in  1  FTDI TXE#; low means space is available (asynchronous)
adbus_in  in  8  ADBUS value sampled from the pins
adbus_out  out  8  value driven on ADBUS when adbus_tri=1
adbus_tri  out  1  1 = FPGA drives ADBUS, 0 = high-Z
ftdi_rd_n  out  1  RD# strobe, active-low
ftdi_wr_n  out  1  WR# strobe, active-low
rx_data  out  8  byte read from the host
rx_valid  out  1  rx_data holds a byte
rx_ready  in  1  consumer takes the byte
tx_data  in  8  byte to send to the host
tx_valid  in  1  producer offers a byte
tx_ready  out  1  one-entry transmit buffer is empty
busy  out  1  FSM is not in IDLE

Behaviour:
- Reset values:
  - ftdi_rd_n=1, ftdi_wr_n=1, adbus_tri=0, adbus_out=0.
  - rx_valid=0, rx_data=0, tx_ready=1, busy=0.
  - Synchroniser flops reset to 1 (flags inactive).
  - The read/write priority bit resets to "read first".
- rxf_n and txe_n each pass through a 2-flop synchroniser. Only the synchronised rxf_s and txe_s feed the FSM.
- RX holding register (one entry):
  - rx_valid stays high until a cycle where rx_ready=1.
  - rx_data is stable while rx_valid=1.
- TX holding register (one entry):
  - The transfer happens when tx_valid and tx_ready are both 1. tx_ready drops the next cycle.
  - tx_ready returns high the cycle after WR# rises.
- Read eligibility: rxf_s=0 and the RX register is empty, or is being emptied this cycle.
- Write eligibility: txe_s=0 and the TX register is full.
- FSM states: IDLE, RD_STROBE, RD_RECOVER, TURN_OUT, WR_SETUP, WR_STROBE, WR_RECOVER, TURN_IN.
- IDLE:
  - Read eligible only: go to RD_STROBE.
  - Write eligible only: go to TURN_OUT.
  - Both eligible: take the operation opposite to the last one completed (round-robin).
- RD_STROBE:
  - ftdi_rd_n=0 for RD_PULSE_CYCLES.
  - On the last cycle, latch adbus_in into rx_data and set rx_valid=1 from the next cycle.
  - Then go to RD_RECOVER.
- RD_RECOVER: rd_n=1 for RECOVER_CYCLES, then IDLE.
- TURN_OUT: adbus_tri=0 for TURN_CYCLES, then WR_SETUP.
- WR_SETUP:
  - adbus_tri=1 and adbus_out=tx buffer contents for SETUP_CYCLES.
  - Then WR_STROBE.
- WR_STROBE: wr_n=0 for WR_PULSE_CYCLES, with data held.
- WR_RECOVER:
  - wr_n=1 and data still driven for one cycle.
  - tx buffer freed.
  - Then TURN_IN.
- TURN_IN: adbus_tri=0 for RECOVER_CYCLES, then IDLE.
- ADBUS direction:
  - adbus_tri=1 only in WR_SETUP, WR_STROBE and WR_RECOVER.
  - RD# is never low while adbus_tri=1.
- Read latency: first RD# low 3 cycles after the raw rxf_n falls (sync 2 + IDLE 1). rx_valid rises RD_PULSE_CYCLES+1 cycles later.
- Throughput with defaults:
  - Back-to-back reads: 7 cycles per byte.
  - A write from IDLE: 2+1+4+1+3 = 11 cycles.
- A flag that deasserts mid-strobe does not abort the strobe. Flags are re-evaluated only in IDLE.
- Reset mid-operation: strobes go high and adbus_tri goes to 0 in the cycle after reset is sampled. Any partially read or written byte is discarded.
- No combinational path from rx_ready or tx_valid to any FTDI pin output.

Decomposition:
- ftdi_pkg holds:
  - the ftdi_state_t enum (8 states above);
  - the counter width constant CNT_W=4;
  - the defaults for the timing parameters.
- One sub-module, sync2: a 1-bit, 2-flop synchroniser with reset value 1. It is instantiated for rxf_n and txe_n.
- A single down-counter, loaded on each state entry, provides all state timing.

Test Plan:
1. Single read:
   - Stimulus: hold rx_ready=0, drop rxf_n at cycle 10, FTDI model drives 8'hA5.
   - Required: rd_n low cycles 13–16; rx_valid=1 with rx_data=A5 from cycle 17; no second RD# until rx_ready pulses.
2. Single write:
   - Stimulus: txe_n=0, offer 8'h3C.
   - Required:
     - adbus_tri rises after 2 idle cycles;
     - wr_n low for exactly 4 cycles with adbus_out=3C throughout;
     - adbus_out stays 3C for 1 cycle after WR# rises;
     - tx_ready=1 again the next cycle.
3. Contention:
   - Stimulus: rxf_n=0 and txe_n=0 held, producer streams 8'h01, 8'h02; consumer is always ready.
   - Required: operations alternate R,W,R,W; RD# and adbus_tri are never both active.
4. Backpressure:
   - Stimulus: 3 host bytes 11, 22, 33; rx_ready low for 20 cycles, then high.
   - Required: only 11 is read during the stall; 22 and 33 follow in order with no loss or duplication.
5. Reset mid-write:
   - Stimulus: assert reset during the 2nd WR_STROBE cycle.
   - Required: next cycle wr_n=1, adbus_tri=0, tx_ready=1, busy=0; the post-reset write of 8'h77 completes normally.
6. Flag glitch:
   - Stimulus: rxf_n low for 1 cycle only, while idle.
   - Required: either exactly one read or none; no RD# pulse shorter than 4 cycles; the FSM returns to IDLE.
